sha256_msg_schedule: RTL and testbench

//  Upstream feeder for the SHA-256 round datapath.
//  - Takes one 512-bit block as 16 big-endian 32-bit words.
//  - Emits the round words W[0..ROUNDS-1], each paired with its round constant K[t], over a valid/ready stream.
//  - The round engine consumes one (W,K) pair per compression round.
//  - A 16-word sliding window expands the words in place: no 64-word storage.

---
 rtl/sha256_msg_schedule.sv | 162 ++++++++++++++++
 tb/tb_sha256_msg_schedule.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads one 512-bit block and streams (W[t], K[t]) pairs from a 16-word window.
// Define SHA256_KROM_EN to build the on-chip K ROM; otherwise k_data is tied to zero.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting the 16 big-endian message words
// RUN   | emitting one (W, K) pair per accepted handshake
module sha256_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        wr_valid,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    output logic [31:0] k_data,
    output logic [5:0]  round,
    output logic        last,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] window [16];
    logic [3:0]  load_cnt;
    logic        restart;
    logic        load_en;
    logic        run_en;
    logic [31:0] expand;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // window[0] is W[t]; the new entry is W[t+16]
    assign expand = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        w_valid   = 1'b0;
        restart   = 1'b0;
        load_en   = 1'b0;
        run_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                wr_ready = 1'b1;
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = LOAD;
                end else if (wr_valid) begin
                    load_en = 1'b1;
                    if (load_cnt == 4'd15) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                w_valid = 1'b1;
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = LOAD;
                end else if (w_ready) begin
                    run_en = 1'b1;
                    if (round == LAST_ROUND) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                window[i] <= '0;
            end
            load_cnt <= '0;
            round    <= '0;
        end else if (restart) begin
            load_cnt <= '0;
            round    <= '0;
        end else if (load_en) begin
            for (int i = 0; i < 15; i++) begin
                window[i] <= window[i+1];
            end
            window[15] <= wr_data;
            load_cnt   <= load_cnt + 4'd1;
            if (load_cnt == 4'd15) begin
                round <= '0;
            end
        end else if (run_en) begin
            for (int i = 0; i < 15; i++) begin
                window[i] <= window[i+1];
            end
            window[15] <= expand;
            round      <= (round == LAST_ROUND) ? 6'd0 : round + 6'd1;
        end
    end

`ifdef SHA256_KROM_EN
    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    assign k_data = K_ROM[round];
`else
    assign k_data = 32'h0;
`endif

    assign w_data = window[0];
    assign last   = (state == RUN) && (round == LAST_ROUND);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: table-driven "abc" vectors plus randomized blocks against a 64-word array model.
// Expected K values follow SHA256_KROM_EN exactly as the design does.
module tb_sha256_msg_schedule;

    localparam int ROUNDS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic        w_valid;
    logic        w_ready = 1'b0;
    logic [31:0] w_data;
    logic [31:0] k_data;
    logic [5:0]  round;
    logic        last;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic [31:0] blk [16];
    logic [31:0] mw [64];
    logic [31:0] cap_w [64];
    logic [31:0] cap_k [64];
    logic        cap_last [64];

    typedef struct {
        int          t;
        logic [31:0] w;
        logic [31:0] k;
        logic        lst;
        bit          chk_w;
    } vec_t;
    vec_t tbl [9];

    sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst(rst), .start(start), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .k_data(k_data), .round(round), .last(last), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef SHA256_KROM_EN
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    function automatic logic [31:0] kexp(input int t);
        return KT[t];
    endfunction
`else
    function automatic logic [31:0] kexp(input int t);
        return (t >= 0) ? 32'h0 : 32'h0;
    endfunction
`endif

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model();
        for (int t = 0; t < 16; t++) mw[t] = blk[t];
        for (int t = 16; t < 64; t++) mw[t] = s1(mw[t-2]) + mw[t-7] + s0(mw[t-15]) + mw[t-16];
    endtask

    task automatic random_block();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        build_model();
    endtask

    task automatic abc_block();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_model();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_block(input bit do_start, input int max_gap);
        int gap;
        int accepts;
        int early_valid;
        accepts = 0;
        early_valid = 0;
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                wr_valid = 1'b0;
                tick();
                if (w_valid) early_valid++;
            end
            wr_valid = 1'b1;
            wr_data  = blk[i];
            if (wr_ready) accepts++;
            tick();
            if (w_valid && i < 15) early_valid++;
        end
        check("load_accepts", 32'(accepts), 32'd16);
        check("load_early_w_valid", 32'(early_valid), 32'd0);
        check("first_w_valid", {31'b0, w_valid}, 32'd1);
        check("first_round", {26'b0, round}, 32'd0);
        check("load_done_wr_ready", {31'b0, wr_ready}, 32'd0);
        wr_valid = 1'b0;
    endtask

    task automatic run_block(input int stop_at, input bit bp, output int cyc);
        int t;
        logic prev_stall;
        logic [31:0] pw, pk;
        logic [5:0] pr;
        t = 0;
        cyc = 0;
        prev_stall = 1'b0;
        pw = '0; pk = '0; pr = '0;
        while (t < stop_at && cyc < 2000) begin
            w_ready = bp ? 1'($urandom_range(1, 0)) : 1'b1;
            if (prev_stall) begin
                check("hold_w_data", w_data, pw);
                check("hold_k_data", k_data, pk);
                check("hold_round", {26'b0, round}, {26'b0, pr});
            end
            if (w_valid && w_ready) begin
                check($sformatf("w_data[%0d]", t), w_data, mw[t]);
                check($sformatf("k_data[%0d]", t), k_data, kexp(t));
                check($sformatf("round[%0d]", t), {26'b0, round}, 32'(t));
                check($sformatf("last[%0d]", t), {31'b0, last}, {31'b0, (t == ROUNDS - 1)});
                cap_w[t]    = w_data;
                cap_k[t]    = k_data;
                cap_last[t] = last;
                t++;
            end
            prev_stall = w_valid && !w_ready;
            pw = w_data; pk = k_data; pr = round;
            tick();
            cyc++;
        end
        check("run_accept_count", 32'(t), 32'(stop_at));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_w_valid"}, {31'b0, w_valid}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_round"}, {26'b0, round}, 32'd0);
        check({tag, "_last"}, {31'b0, last}, 32'd0);
        check({tag, "_wr_ready"}, {31'b0, wr_ready}, 32'd0);
    endtask

    initial begin
        int cyc;
        tbl[0] = '{0,  32'h61626380, kexp(0),  1'b0, 1'b1};
        tbl[1] = '{1,  32'h00000000, kexp(1),  1'b0, 1'b1};
        tbl[2] = '{14, 32'h00000000, kexp(14), 1'b0, 1'b1};
        tbl[3] = '{15, 32'h00000018, kexp(15), 1'b0, 1'b1};
        tbl[4] = '{16, 32'h61626380, kexp(16), 1'b0, 1'b1};
        tbl[5] = '{17, 32'h000F0000, kexp(17), 1'b0, 1'b1};
        tbl[6] = '{18, 32'h7DA86405, kexp(18), 1'b0, 1'b1};
        tbl[7] = '{62, 32'h0,        kexp(62), 1'b0, 1'b0};
        tbl[8] = '{63, 32'h0,        kexp(63), 1'b1, 1'b0};

        // reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");
        check("reset_w_data", w_data, 32'h0);
        check("reset_k_data", k_data, kexp(0));

        // "abc" block at full rate
        abc_block();
        load_block(1'b1, 0);
        run_block(64, 1'b0, cyc);
        check("full_rate_cycles", 32'(cyc), 32'd64);
        check_idle("abc_done");
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].chk_w) check($sformatf("tbl_w[%0d]", tbl[i].t), cap_w[tbl[i].t], tbl[i].w);
            check($sformatf("tbl_k[%0d]", tbl[i].t), cap_k[tbl[i].t], tbl[i].k);
            check($sformatf("tbl_last[%0d]", tbl[i].t), {31'b0, cap_last[tbl[i].t]}, {31'b0, tbl[i].lst});
        end

        // backpressure on "abc" and a random block; IDLE ignores wr_valid and w_ready
        abc_block();
        load_block(1'b1, 0);
        run_block(64, 1'b1, cyc);
        check_idle("bp_done");
        random_block();
        load_block(1'b1, 0);
        run_block(64, 1'b1, cyc);
        check_idle("bp_rand_done");

        // load gaps
        for (int n = 0; n < 2; n++) begin
            random_block();
            load_block(1'b1, 3);
            run_block(64, 1'b1, cyc);
            check_idle("gap_done");
        end

        // abort at round 20 with a simultaneous handshake, then a new block
        random_block();
        load_block(1'b1, 0);
        run_block(20, 1'b0, cyc);
        check("abort_at_round", {26'b0, round}, 32'd20);
        start = 1'b1;
        w_ready = 1'b1;
        tick();
        start = 1'b0;
        w_ready = 1'b0;
        check("abort_w_valid", {31'b0, w_valid}, 32'd0);
        check("abort_wr_ready", {31'b0, wr_ready}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd1);
        repeat (3) tick();
        check("abort_no_old_w_valid", {31'b0, w_valid}, 32'd0);
        random_block();
        load_block(1'b0, 0);
        run_block(64, 1'b0, cyc);
        check_idle("abort_new_done");

        // start together with the 10th write accept drops that word
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr_valid = 1'b1;
            wr_data = $urandom;
            tick();
        end
        wr_valid = 1'b1;
        wr_data = 32'hDEADBEEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_valid = 1'b0;
        check("restart10_wr_ready", {31'b0, wr_ready}, 32'd1);
        check("restart10_w_valid", {31'b0, w_valid}, 32'd0);
        random_block();
        load_block(1'b0, 2);
        run_block(64, 1'b1, cyc);
        check_idle("restart10_done");

        // reset mid-RUN at round 37
        random_block();
        load_block(1'b1, 0);
        run_block(37, 1'b0, cyc);
        check("pre_reset_round", {26'b0, round}, 32'd37);
        rst = 1'b1;
        w_ready = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("midrun_reset");
        check("midrun_reset_w_data", w_data, 32'h0);
        wr_valid = 1'b1;
        wr_data = 32'h12345678;
        repeat (3) tick();
        wr_valid = 1'b0;
        check_idle("idle_ignore");
        check("idle_ignore_w_data", w_data, 32'h0);

        // reset outranks start
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check_idle("rst_over_start");

        random_block();
        load_block(1'b1, 1);
        run_block(64, 1'b1, cyc);
        check_idle("recover_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
